baud_tick_generator: RTL and testbench

- Parametrised successor to the fixed-divisor baud rate generator.
- Produces a one-cycle baud tick every DIV cycles, with DIV loadable at run time.
- Also produces a mid-bit tick and an oversampling tick (OSR per bit period) for the UART receiver's start-bit detection and bit sampling.
- Sits between the system clock and the uart_receiver/uart_transmitter FSMs; receiver uses restart to phase-align on the start-bit edge.

---
 rtl/baud_tick_generator.sv | 80 ++++++++
 tb/tb_baud_tick_generator.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/baud_tick_generator.sv
// Bit-period timer with a run-time loadable divisor. Emits baud, mid-bit and
// oversampling strobes for the UART receiver/transmitter FSMs.
module baud_tick_generator #(
   parameter int CNT_W       = 16,
   parameter int OSR         = 16,
   parameter int DEFAULT_DIV = 10417
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [CNT_W-1:0] div_in,
   input  logic             div_load,
   input  logic             restart,
   output logic             baud_tick,
   output logic             half_tick,
   output logic             os_tick,
   output logic [CNT_W-1:0] counter,
   output logic [CNT_W-1:0] div_cur
);

   localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
   localparam logic [CNT_W-1:0] OSR_DIV   = CNT_W'(OSR);
   localparam logic [CNT_W:0]   OSR_ACC   = (CNT_W+1)'(OSR);
   localparam logic [CNT_W-1:0] RESET_DIV = CNT_W'(DEFAULT_DIV);

   logic [CNT_W-1:0] div_q, div_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [CNT_W:0]   acc_q, acc_d;
   logic [CNT_W:0]   acc_sum;
   logic             period_end;
   logic             mid_point;
   logic             os_hit;
   logic             tick_ok;

   // The accumulator adds OSR per cycle modulo div_q, so it crosses div_q
   // exactly OSR times per period and lands back on 0 at the wrap.
   assign acc_sum    = acc_q + OSR_ACC;
   assign os_hit     = (acc_sum >= {1'b0, div_q});
   assign period_end = (cnt_q == div_q - ONE);
   assign mid_point  = (cnt_q == (div_q >> 1) - ONE);
   assign tick_ok    = en & ~rst & ~div_load & ~restart;

   always_comb begin
      // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
      div_d = div_q;
      cnt_d = cnt_q;
      acc_d = acc_q;
      if (div_load) begin
         div_d = (div_in < OSR_DIV) ? OSR_DIV : div_in;
         cnt_d = '0;
         acc_d = '0;
      end else if (restart) begin
         cnt_d = '0;
         acc_d = '0;
      end else if (en) begin
         cnt_d = period_end ? '0 : cnt_q + ONE;
         acc_d = os_hit ? acc_sum - {1'b0, div_q} : acc_sum;
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      if (rst) begin
         div_q <= RESET_DIV;
         cnt_q <= '0;
         acc_q <= '0;
      end else begin
         div_q <= div_d;
         cnt_q <= cnt_d;
         acc_q <= acc_d;
      end
   end

   assign baud_tick = tick_ok & period_end;
   assign half_tick = tick_ok & mid_point;
   assign os_tick   = tick_ok & os_hit;
   assign counter   = cnt_q;
   assign div_cur   = div_q;

endmodule

// File: tb/tb_baud_tick_generator.sv
// Self-checking bench for baud_tick_generator: vector table, directed
// multi-cycle sequences and a randomized run against a closed-form model.
module tb_baud_tick_generator;

   localparam int DIV0 = 10417;
   localparam int OSR  = 16;

   logic        clk = 1'b0;
   logic        rst, en, div_load, restart;
   logic [15:0] div_in;
   logic        baud_tick, half_tick, os_tick;
   logic [15:0] counter, div_cur;

   logic        s_baud, s_half, s_os;
   logic [15:0] s_cnt, s_div;

   int checks = 0;
   int errors = 0;

   baud_tick_generator #(.CNT_W(16), .OSR(OSR), .DEFAULT_DIV(DIV0)) dut (
      .clk(clk), .rst(rst), .en(en), .div_in(div_in), .div_load(div_load),
      .restart(restart), .baud_tick(baud_tick), .half_tick(half_tick),
      .os_tick(os_tick), .counter(counter), .div_cur(div_cur)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst, en, ld;
      logic [15:0] din;
      logic        rs;
      logic        baud, half, os;
      logic [15:0] cnt, div;
   } vec_t;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Apply inputs away from the edge, snapshot outputs, then let one posedge pass.
   task automatic cyc(input logic r, input logic e, input logic l, input logic [15:0] d, input logic s);
      rst = r; en = e; div_load = l; div_in = d; restart = s;
      #1;
      s_baud = baud_tick; s_half = half_tick; s_os = os_tick;
      s_cnt = counter; s_div = div_cur;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic do_reset();
      cyc(1, 1, 0, 16'd0, 0);
      cyc(1, 1, 0, 16'd0, 0);
   endtask

   vec_t vecs[13];

   initial begin
      #5_000_000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int first_b, second_b, nb, cnt_at_b, os_at_b, nos1, last_os, gmin, gmax;
      int nh, first_h, half_bad, bad, found;
      int m_div, m_phase;

      @(negedge clk);

      // ---------------- vector table ----------------
      //          rst en ld  din  rs  baud half os  cnt  div
      vecs[0]  = '{1, 1, 0, 16'd0,   0, 0, 0, 0, 16'd0, 16'd10417};
      vecs[1]  = '{0, 1, 0, 16'd0,   0, 0, 0, 0, 16'd0, 16'd10417};
      vecs[2]  = '{0, 1, 1, 16'd3,   0, 0, 0, 0, 16'd1, 16'd10417};
      vecs[3]  = '{0, 1, 0, 16'd0,   0, 0, 0, 1, 16'd0, 16'd16};
      vecs[4]  = '{0, 0, 0, 16'd0,   0, 0, 0, 0, 16'd1, 16'd16};
      vecs[5]  = '{0, 1, 0, 16'd0,   1, 0, 0, 0, 16'd1, 16'd16};
      vecs[6]  = '{0, 1, 0, 16'd0,   0, 0, 0, 1, 16'd0, 16'd16};
      vecs[7]  = '{0, 1, 1, 16'd40,  1, 0, 0, 0, 16'd1, 16'd16};
      vecs[8]  = '{0, 1, 0, 16'd0,   0, 0, 0, 0, 16'd0, 16'd40};
      vecs[9]  = '{0, 1, 0, 16'd0,   0, 0, 0, 0, 16'd1, 16'd40};
      vecs[10] = '{0, 1, 0, 16'd0,   0, 0, 0, 1, 16'd2, 16'd40};
      vecs[11] = '{1, 1, 1, 16'd100, 0, 0, 0, 0, 16'd3, 16'd40};
      vecs[12] = '{0, 1, 0, 16'd0,   0, 0, 0, 0, 16'd0, 16'd10417};

      do_reset();
      for (int i = 0; i < 13; i++) begin
         cyc(vecs[i].rst, vecs[i].en, vecs[i].ld, vecs[i].din, vecs[i].rs);
         check($sformatf("vec%0d", i), {s_baud, s_half, s_os, s_cnt, s_div},
               {vecs[i].baud, vecs[i].half, vecs[i].os, vecs[i].cnt, vecs[i].div});
      end

      // ---------------- free run at the default divisor ----------------
      do_reset();
      first_b = -1; second_b = -1; nb = 0; cnt_at_b = -1; os_at_b = 0; nos1 = 0;
      last_os = -1; gmin = 1_000_000; gmax = 0; nh = 0; first_h = -1; half_bad = 0;
      for (int i = 0; i < 2 * DIV0; i++) begin
         cyc(0, 1, 0, 16'd0, 0);
         if (s_baud) begin
            nb++;
            if (first_b < 0) begin first_b = i; cnt_at_b = int'(s_cnt); end
            else if (second_b < 0) second_b = i;
            if (s_os) os_at_b++;
         end
         if (s_os) begin
            if (i < DIV0) nos1++;
            if (last_os >= 0) begin
               if (i - last_os < gmin) gmin = i - last_os;
               if (i - last_os > gmax) gmax = i - last_os;
            end
            last_os = i;
         end
         if (s_half) begin
            nh++;
            if (first_h < 0) first_h = i;
            if (s_cnt != 16'd5207) half_bad++;
         end
      end
      check("free_first_baud", first_b, 10416);
      check("free_second_baud", second_b, 20833);
      check("free_baud_count", nb, 2);
      check("free_cnt_at_baud", cnt_at_b, 10416);
      check("os_per_period", nos1, 16);
      check("os_with_baud", os_at_b, 2);
      check("os_gap_min", gmin, 651);
      check("os_gap_max", gmax, 652);
      check("half_count", nh, 2);
      check("half_first", first_h, 5207);
      check("half_counter", half_bad, 0);

      // ---------------- mid-period div_load ----------------
      do_reset();
      for (int i = 0; i < 3000; i++) cyc(0, 1, 0, 16'd0, 0);
      cyc(0, 1, 1, 16'd5208, 0);
      check("load_cnt_before", s_cnt, 3000);
      check("load_masked", {s_baud, s_half, s_os}, 0);
      first_b = -1; second_b = -1; cnt_at_b = -1;
      for (int i = 0; i < 2 * 5208; i++) begin
         cyc(0, 1, 0, 16'd0, 0);
         if (i == 0) begin
            check("load_cnt_after", s_cnt, 0);
            check("load_div_after", s_div, 5208);
         end
         if (s_baud) begin
            if (first_b < 0) begin first_b = i; cnt_at_b = int'(s_cnt); end
            else if (second_b < 0) second_b = i;
         end
      end
      check("load_first_baud", first_b, 5207);
      check("load_cnt_at_baud", cnt_at_b, 5207);
      check("load_period", second_b - first_b, 5208);

      // ---------------- clamp to OSR ----------------
      cyc(0, 1, 1, 16'd3, 0);
      nb = 0; nos1 = 0; first_b = -1;
      for (int i = 0; i < 48; i++) begin
         cyc(0, 1, 0, 16'd0, 0);
         if (i == 0) check("clamp_div", s_div, 16);
         if (s_os) nos1++;
         if (s_baud) begin nb++; if (first_b < 0) first_b = i; end
      end
      check("clamp_os_every_cycle", nos1, 48);
      check("clamp_baud_count", nb, 3);
      check("clamp_first_baud", first_b, 15);

      // ---------------- enable low freezes ----------------
      do_reset();
      for (int i = 0; i < 500; i++) cyc(0, 1, 0, 16'd0, 0);
      bad = 0;
      for (int i = 0; i < 100; i++) begin
         cyc(0, 0, 0, 16'd0, 0);
         if (s_cnt != 16'd500 || s_baud || s_half || s_os) bad++;
      end
      check("en_low_frozen", bad, 0);
      found = -1;
      for (int i = 0; i < 12000 && found < 0; i++) begin
         cyc(0, 1, 0, 16'd0, 0);
         if (s_baud) found = i;
      end
      check("en_resume_baud", found, 9916);

      // ---------------- restart mid-period ----------------
      do_reset();
      for (int i = 0; i < 7000; i++) cyc(0, 1, 0, 16'd0, 0);
      cyc(0, 1, 0, 16'd0, 1);
      check("restart_cnt_before", s_cnt, 7000);
      found = -1;
      for (int j = 1; j < 12000 && found < 0; j++) begin
         cyc(0, 1, 0, 16'd0, 0);
         if (j == 1) check("restart_cnt_after", s_cnt, 0);
         if (s_baud) found = j;
      end
      check("restart_next_baud", found, 10417);

      // ---------------- simultaneous strobes ----------------
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 16'd0, 0);
      cyc(0, 1, 1, 16'd50, 1);
      cyc(0, 1, 0, 16'd0, 0);
      check("load_beats_restart", {s_cnt, s_div}, {16'd0, 16'd50});
      for (int i = 0; i < 5; i++) cyc(0, 1, 0, 16'd0, 0);
      cyc(1, 1, 1, 16'd77, 0);
      cyc(0, 1, 0, 16'd0, 0);
      check("rst_beats_load", {s_cnt, s_div}, {16'd0, 16'(DIV0)});

      // ---------------- randomized run against a closed-form model ----------------
      do_reset();
      m_div = DIV0; m_phase = 0;
      cyc(0, 1, 1, 16'd37, 0);
      m_div = 37; m_phase = 0;
      for (int i = 0; i < 6000; i++) begin
         logic r, e, l, s, act, eb, eh, eo;
         logic [15:0] d;
         r = ($urandom_range(0, 299) == 0);
         l = ($urandom_range(0, 59) == 0);
         s = ($urandom_range(0, 49) == 0);
         e = ($urandom_range(0, 7) != 0);
         d = ($urandom_range(0, 3) == 0) ? 16'($urandom_range(0, 300)) : 16'($urandom_range(0, 40));
         act = e && !r && !l && !s;
         eb = act && (m_phase == m_div - 1);
         eh = act && (m_phase == m_div / 2 - 1);
         eo = act && (((m_phase + 1) * OSR) / m_div > (m_phase * OSR) / m_div);
         cyc(r, e, l, d, s);
         check($sformatf("rand%0d", i), {s_baud, s_half, s_os, s_cnt, s_div},
               {eb, eh, eo, 16'(m_phase), 16'(m_div)});
         if (r) begin m_div = DIV0; m_phase = 0; end
         else if (l) begin m_div = (int'(d) < OSR) ? OSR : int'(d); m_phase = 0; end
         else if (s) m_phase = 0;
         else if (e) m_phase = (m_phase + 1) % m_div;
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
